minsoc_rst_gen: RTL and testbench



---
 rtl/minsoc_rst_gen.sv | 195 +++++++++++++++++++
 tb/tb_minsoc_rst_gen.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/minsoc_rst_gen.sv
// System reset generator for the divided DCM clock domain: synchronizes and
// debounces the board button and stretches every reset to HOLD_CYCLES low samples.
// Optional macro RST_GEN_LOCK_WAIT_EN adds dcm_locked_i and the LOCKWAIT state.
module minsoc_rst_gen #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int HOLD_CYCLES     = 64,
    parameter int CNT_W           = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       btn_rst_i,
`ifdef RST_GEN_LOCK_WAIT_EN
    input  logic       dcm_locked_i,
`endif
    output logic       rst_o,
    output logic       rst_n_o,
    output logic       run_o,
    output logic [1:0] rst_cause_o
);

    typedef enum logic [2:0] {
        ST_HOLD,
        ST_RUN,
        ST_DEBOUNCE,
        ST_ASSERT,
        ST_LOCKWAIT
    } state_e;

    localparam logic [1:0] CAUSE_RST  = 2'b00;
    localparam logic [1:0] CAUSE_BTN  = 2'b01;
    localparam logic [1:0] CAUSE_LOCK = 2'b10;

    localparam int MAX_CNT = (DEBOUNCE_CYCLES > HOLD_CYCLES) ? DEBOUNCE_CYCLES : HOLD_CYCLES;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEB_LAST  = (DEBOUNCE_CYCLES > 1) ? CNT_W'(DEBOUNCE_CYCLES - 2) : '0;

    generate
        if (SYNC_STAGES < 2) begin : g_bad_sync
            $error("minsoc_rst_gen: SYNC_STAGES must be at least 2");
        end
        if (DEBOUNCE_CYCLES < 1 || HOLD_CYCLES < 1) begin : g_bad_cycles
            $error("minsoc_rst_gen: DEBOUNCE_CYCLES and HOLD_CYCLES must be at least 1");
        end
        if (longint'(MAX_CNT - 1) >= (longint'(1) << CNT_W)) begin : g_bad_cnt_w
            $error("minsoc_rst_gen: CNT_W too narrow for max(DEBOUNCE_CYCLES, HOLD_CYCLES)-1");
        end
    endgenerate

    logic [SYNC_STAGES-1:0] btn_sync_q;
    logic                   btn_s;
    logic                   lock_s;
    logic                   init_wait;

    always_ff @(posedge clk_i) begin
        if (rst_i) btn_sync_q <= '0;
        else       btn_sync_q <= {btn_sync_q[SYNC_STAGES-2:0], btn_rst_i};
    end
    assign btn_s = btn_sync_q[SYNC_STAGES-1];

`ifdef RST_GEN_LOCK_WAIT_EN
    logic [SYNC_STAGES-1:0] lock_sync_q;
    logic                   init_wait_q;

    // init_wait_q marks the lock wait right after rst_i, which keeps cause 00.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lock_sync_q <= '0;
            init_wait_q <= 1'b1;
        end else begin
            lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], dcm_locked_i};
            if (lock_s) init_wait_q <= 1'b0;
        end
    end
    assign lock_s    = lock_sync_q[SYNC_STAGES-1];
    assign init_wait = init_wait_q;
`else
    assign lock_s    = 1'b1;
    assign init_wait = 1'b0;
`endif

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       cause_q, cause_d;
    logic             rst_q, rst_n_q, run_q;
    logic             rst_d, run_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cause_d = cause_q;
        if (!lock_s) begin
            if (init_wait && state_q == ST_HOLD) begin
                cnt_d = '0;
            end else if (state_q != ST_LOCKWAIT) begin
                state_d = ST_LOCKWAIT;
                cnt_d   = '0;
                cause_d = CAUSE_LOCK;
            end
        end else begin
            case (state_q)
                ST_HOLD: begin
                    if (btn_s) begin
                        state_d = ST_ASSERT;
                        cnt_d   = '0;
                        cause_d = CAUSE_BTN;
                    end else if (cnt_q == HOLD_LAST) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (btn_s) begin
                        cnt_d = '0;
                        if (DEBOUNCE_CYCLES == 1) begin
                            state_d = ST_ASSERT;
                            cause_d = CAUSE_BTN;
                        end else begin
                            state_d = ST_DEBOUNCE;
                        end
                    end
                end
                ST_DEBOUNCE: begin
                    if (!btn_s) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end else if (cnt_q == DEB_LAST) begin
                        state_d = ST_ASSERT;
                        cnt_d   = '0;
                        cause_d = CAUSE_BTN;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_ASSERT: begin
                    // The exit edge already sampled btn_s low, so it is hold sample #1.
                    if (!btn_s) begin
                        if (HOLD_CYCLES == 1) begin
                            state_d = ST_RUN;
                            cnt_d   = '0;
                        end else begin
                            state_d = ST_HOLD;
                            cnt_d   = CNT_W'(1);
                        end
                    end
                end
                ST_LOCKWAIT: begin
                    if (btn_s) begin
                        state_d = ST_HOLD;
                        cnt_d   = '0;
                    end else if (HOLD_CYCLES == 1) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_HOLD;
                        cnt_d   = CNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign rst_d = (state_d == ST_HOLD) || (state_d == ST_ASSERT) || (state_d == ST_LOCKWAIT);
    assign run_d = (state_d == ST_RUN) || (state_d == ST_DEBOUNCE);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_HOLD;
            cnt_q   <= '0;
            cause_q <= CAUSE_RST;
            rst_q   <= 1'b1;
            rst_n_q <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cause_q <= cause_d;
            rst_q   <= rst_d;
            rst_n_q <= ~rst_d;
            run_q   <= run_d;
        end
    end

    assign rst_o       = rst_q;
    assign rst_n_o     = rst_n_q;
    assign run_o       = run_q;
    assign rst_cause_o = cause_q;

endmodule

// File: tb/tb_minsoc_rst_gen.sv
// Bench for minsoc_rst_gen: a sample-count reference model checked every cycle,
// plus directed scenarios with hand-computed edge latencies.
module tb_minsoc_rst_gen;

    localparam int SYNC = 2;
    localparam int DEB  = 16;
    localparam int HOLD = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn = 1'b0;
    logic       rst_o, rst_n_o, run_o;
    logic [1:0] cause;

    int n_chk  = 0;
    int n_fail = 0;

    minsoc_rst_gen #(
        .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .HOLD_CYCLES(HOLD), .CNT_W(16)
    ) dut (
        .clk_i(clk), .rst_i(rst), .btn_rst_i(btn),
        .rst_o(rst_o), .rst_n_o(rst_n_o), .run_o(run_o), .rst_cause_o(cause)
    );

    always #5 clk = ~clk;

    // Model: reset is held until HOLD consecutive low samples of the synchronized
    // button, and raised after DEB consecutive high samples while running.
    logic [SYNC-1:0] m_hist;
    logic            m_in_rst;
    int              m_low, m_high;
    logic [1:0]      m_cause;
    logic            m_valid = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_hist   <= '0;
            m_in_rst <= 1'b1;
            m_low    <= 0;
            m_high   <= 0;
            m_cause  <= 2'b00;
            m_valid  <= 1'b1;
        end else begin
            m_hist <= {m_hist[SYNC-2:0], btn};
            if (m_in_rst) begin
                if (m_hist[SYNC-1]) begin
                    m_low   <= 0;
                    m_cause <= 2'b01;
                end else if (m_low + 1 == HOLD) begin
                    m_in_rst <= 1'b0;
                    m_high   <= 0;
                end else begin
                    m_low <= m_low + 1;
                end
            end else begin
                if (!m_hist[SYNC-1]) begin
                    m_high <= 0;
                end else if (m_high + 1 == DEB) begin
                    m_in_rst <= 1'b1;
                    m_low    <= 0;
                    m_cause  <= 2'b01;
                end else begin
                    m_high <= m_high + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            n_chk++;
            if ({rst_o, rst_n_o, run_o, cause} !== {m_in_rst, ~m_in_rst, ~m_in_rst, m_cause}) begin
                n_fail++;
                $display("FAIL model_cmp t=%0t: dut rst=%b rst_n=%b run=%b cause=%b, model rst=%b cause=%b",
                         $time, rst_o, rst_n_o, run_o, cause, m_in_rst, m_cause);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Counts edges until rst_o reaches val; -1 if the bound expires.
    task automatic wait_rst(input logic val, input int max_edges, output int n);
        n = -1;
        for (int k = 1; k <= max_edges; k++) begin
            step();
            if (rst_o === val) begin
                n = k;
                break;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        @(negedge clk);
        repeat (3) step();
        chk("reset_rst_o", 32'(rst_o), 1);
        chk("reset_rst_n_o", 32'(rst_n_o), 0);
        chk("reset_run_o", 32'(run_o), 0);
        chk("reset_cause", 32'(cause), 0);

        // Power-up release.
        rst = 1'b0;
        wait_rst(1'b0, 200, n);
        chk("powerup_release_edges", n, 64);
        chk("powerup_run_o", 32'(run_o), 1);
        chk("powerup_rst_n_o", 32'(rst_n_o), 1);
        chk("powerup_cause", 32'(cause), 0);

        // Glitch of 10 cycles is rejected.
        btn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("glitch_rst_o", 32'(rst_o), 0);
        end
        btn = 1'b0;
        repeat (6) step();
        chk("glitch_run_o", 32'(run_o), 1);

        // 15 high cycles: one short of the debounce threshold.
        btn = 1'b1;
        repeat (15) step();
        btn = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("deb15_rst_o", 32'(rst_o), 0);
        end

        // Exactly 16 high cycles: reset on edge 18, release 66 edges after the fall.
        btn = 1'b1;
        repeat (16) step();
        btn = 1'b0;
        step();
        chk("deb16_edge17_rst_o", 32'(rst_o), 0);
        step();
        chk("deb16_edge18_rst_o", 32'(rst_o), 1);
        wait_rst(1'b0, 200, n);
        chk("deb16_release_edges", n + 2, 66);

        // Button held 100 cycles.
        btn = 1'b1;
        wait_rst(1'b1, 200, n);
        chk("press_assert_edges", n, 18);
        chk("press_cause", 32'(cause), 1);
        chk("press_run_o", 32'(run_o), 0);
        repeat (100 - 18) step();
        btn = 1'b0;
        wait_rst(1'b0, 200, n);
        chk("press_release_edges", n, 66);
        chk("press_cause_after", 32'(cause), 1);

        // Re-press during HOLD restarts the hold count.
        btn = 1'b1;
        wait_rst(1'b1, 200, n);
        chk("repress_assert_edges", n, 18);
        repeat (5) step();
        btn = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step();
            chk("repress_hold_rst_o", 32'(rst_o), 1);
        end
        btn = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("repress_press_rst_o", 32'(rst_o), 1);
        end
        btn = 1'b0;
        wait_rst(1'b0, 200, n);
        chk("repress_release_edges", n, 66);

        // rst_i in ASSERT with the button still high.
        btn = 1'b1;
        wait_rst(1'b1, 200, n);
        chk("midrst_assert_edges", n, 18);
        repeat (4) step();
        rst = 1'b1;
        step();
        chk("midrst_rst_o", 32'(rst_o), 1);
        chk("midrst_run_o", 32'(run_o), 0);
        chk("midrst_cause", 32'(cause), 0);
        rst = 1'b0;
        btn = 1'b0;
        wait_rst(1'b0, 200, n);
        chk("midrst_release_edges", n, 64);
        chk("midrst_cause_after", 32'(cause), 0);

        repeat (4) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
